vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 67 ++++++
 rtl/vga_timing_gen.sv | 171 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose : Bundles the raster timing outputs of vga_timing_gen so that the
//           generator and its consumers (PPU-to-VGA path, frame-synchronous
//           logic) share one connection.
//
// Parameters
//   CNT_W        coordinate width
//   FRAME_CNT_W  frame counter width (frame_cnt exists only when the macro
//                VGA_TIMING_FRAME_CNT_EN is defined)
//
// Signals (driven by the master = timing generator)
//   hsync, vsync    registered sync levels
//   en              registered display enable (lags x/y by one clk)
//   vblank          registered vertical blanking (lags y by one clk)
//   x, y            current raster counters
//   x_next, y_next  next raster position in scan order
//   pix_tick        high on the clk where the counters advance
//   line_start      one-clk pulse on the first clk of a new line
//   frame_start     one-clk pulse on the first clk of a new frame
//   frame_cnt       frame counter (VGA_TIMING_FRAME_CNT_EN only)
//
// Modports: master (generator), slave (consumer).
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
   parameter int CNT_W       = 10,
   parameter int FRAME_CNT_W = 8
);
   logic             hsync;
   logic             vsync;
   logic             en;
   logic             vblank;
   logic [CNT_W-1:0] x;
   logic [CNT_W-1:0] y;
   logic [CNT_W-1:0] x_next;
   logic [CNT_W-1:0] y_next;
   logic             pix_tick;
   logic             line_start;
   logic             frame_start;

   if (FRAME_CNT_W < 1) begin : g_bad_frame_w
      $error("vga_timing_gen_if: FRAME_CNT_W must be >= 1");
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt;

   modport master (
      output hsync, vsync, en, vblank, x, y, x_next, y_next,
             pix_tick, line_start, frame_start, frame_cnt
   );
   modport slave (
      input  hsync, vsync, en, vblank, x, y, x_next, y_next,
             pix_tick, line_start, frame_start, frame_cnt
   );
`else
   modport master (
      output hsync, vsync, en, vblank, x, y, x_next, y_next,
             pix_tick, line_start, frame_start
   );
   modport slave (
      input  hsync, vsync, en, vblank, x, y, x_next, y_next,
             pix_tick, line_start, frame_start
   );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose : Parametrised VGA-style raster timing generator. A clock divider
//           derives the pixel rate from i_clk; x/y counters walk the raster
//           and registered sync / enable / blanking / strobe outputs are
//           derived from them.
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
//   defined     -> o_vga.frame_cnt exists and counts frames modulo
//                  2^FRAME_CNT_W, stepping on the same edge frame_start rises
//   not defined -> no frame counter; everything else is identical
//
// Ports
//   i_clk   system clock
//   i_rst   synchronous active-high reset (priority over every event)
//   o_vga   vga_timing_gen_if.master:
//             hsync/vsync  registered, active level per HSYNC_POL/VSYNC_POL
//             en           registered, previous clock's (x,y) is visible
//             vblank       registered, previous clock's y >= V_DISP
//             x, y         current counters
//             x_next/y_next next position in scan order (combinational)
//             pix_tick     combinational, high when counters advance
//             line_start   registered pulse on first clk with new x==0
//             frame_start  registered pulse on first clk with new (0,0)
//             frame_cnt    frame count (macro only)
//
// Timing note: hsync, vsync, en and vblank lag x/y by exactly one clk, so
// downstream RGB logic must register its output once to stay aligned.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_DISP      = 640,
   parameter int H_FP        = 16,
   parameter int H_RT        = 96,
   parameter int H_BP        = 48,
   parameter int V_DISP      = 480,
   parameter int V_FP        = 10,
   parameter int V_RT        = 2,
   parameter int V_BP        = 33,
   parameter int CLK_DIV     = 2,
   parameter bit HSYNC_POL   = 1'b1,
   parameter bit VSYNC_POL   = 1'b1,
   parameter int CNT_W       = 10,
   parameter int FRAME_CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   vga_timing_gen_if.master o_vga
);

   localparam int H_TOTAL = H_DISP + H_FP + H_RT + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_RT + V_BP;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_MAX    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_MAX    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISP);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISP);
   // Sync windows expressed as inclusive first/last so the upper bound never
   // needs a value of TOTAL, which may not fit in CNT_W.
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISP + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISP + H_FP + H_RT - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISP + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISP + V_FP + V_RT - 1);

   // Elaboration-time parameter sanity checks
   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be >= 1");
   end
   if ((H_TOTAL > (1 << CNT_W)) || (V_TOTAL > (1 << CNT_W))) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
   end
   if ((H_RT < 1) || (V_RT < 1) || (FRAME_CNT_W < 1)) begin : g_bad_widths
      $error("vga_timing_gen: H_RT, V_RT and FRAME_CNT_W must be >= 1");
   end

   // Registers
   logic [DIV_W-1:0] r_q_div;
   logic [CNT_W-1:0] r_x;
   logic [CNT_W-1:0] r_y;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_en;
   logic             r_vblank;
   logic             r_line_start;
   logic             r_frame_start;

   // Combinational
   logic             w_pix_tick;
   logic             w_x_end;
   logic             w_y_end;
   logic             w_line_pulse;
   logic             w_frame_pulse;
   logic [CNT_W-1:0] w_x_next;
   logic [CNT_W-1:0] w_y_next;
   logic             w_hs_act;
   logic             w_vs_act;

   // With CLK_DIV=1 DIV_MAX is 0 and r_q_div stays 0, so pix_tick is constant 1.
   assign w_pix_tick    = (r_q_div == DIV_MAX);
   assign w_x_end       = (r_x == H_MAX);
   assign w_y_end       = (r_y == V_MAX);
   assign w_line_pulse  = w_pix_tick && w_x_end;
   assign w_frame_pulse = w_line_pulse && w_y_end;

   // Look-ahead position, independent of pix_tick
   assign w_x_next = w_x_end ? '0 : r_x + CNT_W'(1);
   assign w_y_next = w_x_end ? (w_y_end ? '0 : r_y + CNT_W'(1)) : r_y;

   assign w_hs_act = (r_x >= HS_FIRST) && (r_x <= HS_LAST);
   assign w_vs_act = (r_y >= VS_FIRST) && (r_y <= VS_LAST);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q_div       <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_hsync       <= ~HSYNC_POL;
         r_vsync       <= ~VSYNC_POL;
         r_en          <= 1'b0;
         r_vblank      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_q_div <= w_pix_tick ? '0 : r_q_div + DIV_W'(1);

         if (w_pix_tick) begin
            r_x <= w_x_end ? '0 : r_x + CNT_W'(1);
         end
         if (w_line_pulse) begin
            r_y <= w_y_end ? '0 : r_y + CNT_W'(1);
         end

         // Decoded from the pre-edge counters: one clk behind x/y
         r_hsync       <= w_hs_act ? HSYNC_POL : ~HSYNC_POL;
         r_vsync       <= w_vs_act ? VSYNC_POL : ~VSYNC_POL;
         r_en          <= (r_x < H_VIS) && (r_y < V_VIS);
         r_vblank      <= (r_y >= V_VIS);
         r_line_start  <= w_line_pulse;
         r_frame_start <= w_frame_pulse;
      end
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] r_frame_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_frame_cnt <= '0;
      end else if (w_frame_pulse) begin
         r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
      end
   end

   assign o_vga.frame_cnt = r_frame_cnt;
`endif

   assign o_vga.hsync       = r_hsync;
   assign o_vga.vsync       = r_vsync;
   assign o_vga.en          = r_en;
   assign o_vga.vblank      = r_vblank;
   assign o_vga.x           = r_x;
   assign o_vga.y           = r_y;
   assign o_vga.x_next      = w_x_next;
   assign o_vga.y_next      = w_y_next;
   assign o_vga.pix_tick    = w_pix_tick;
   assign o_vga.line_start  = r_line_start;
   assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two generators share one clock: u_big with default 640x480 timing
// (CLK_DIV=2) and u_small with a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1,
// CLK_DIV=1, HSYNC_POL=0). The small raster is checked from a table of
// hand-computed vectors; the default one with hand-written timing sequences.
// Define VGA_TIMING_FRAME_CNT_EN to also check the frame counter.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_big   = 1'b1;
   logic rst_small = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   vga_timing_gen_if #(.CNT_W(10), .FRAME_CNT_W(8)) big_if ();
   vga_timing_gen_if #(.CNT_W(4),  .FRAME_CNT_W(2)) small_if ();

   vga_timing_gen u_big (
      .i_clk (clk),
      .i_rst (rst_big),
      .o_vga (big_if)
   );

   vga_timing_gen #(
      .H_DISP(4), .H_FP(1), .H_RT(2), .H_BP(1),
      .V_DISP(3), .V_FP(1), .V_RT(1), .V_BP(1),
      .CLK_DIV(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b1),
      .CNT_W(4), .FRAME_CNT_W(2)
   ) u_small (
      .i_clk (clk),
      .i_rst (rst_small),
      .o_vga (small_if)
   );

   // ---------------- helpers ----------------
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Advance n clock edges and land 1 time unit after the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- small-raster vector table ----------------
   // rst is held for n_clk edges, then all outputs are compared.
   typedef struct {
      bit rst;
      int n_clk;
      int x;
      int y;
      int xn;
      int yn;
      bit hs;
      bit vs;
      bit en;
      bit vb;
      bit ls;
      bit fs;
   } vec_t;

   vec_t vecs[14];

   initial begin
      int t;
      int cnt;
      int early;

      // k = edges since reset release; x = k%8, y = (k/8)%6.
      // Registered outputs describe position k-1. hsync (active low) is
      // asserted for prev x in {5,6}; vsync for prev y == 4.
      //            rst n   x  y  xn yn hs vs en vb ls fs
      vecs[0]  = '{1, 3,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0}; // reset state
      vecs[1]  = '{0, 1,  1, 0, 2, 0, 1, 0, 1, 0, 0, 0}; // k=1, en from (0,0)
      vecs[2]  = '{0, 4,  5, 0, 6, 0, 1, 0, 0, 0, 0, 0}; // k=5, prev x=4 blank
      vecs[3]  = '{0, 1,  6, 0, 7, 0, 0, 0, 0, 0, 0, 0}; // k=6, prev x=5 sync
      vecs[4]  = '{0, 1,  7, 0, 0, 1, 0, 0, 0, 0, 0, 0}; // k=7, line end lookahead
      vecs[5]  = '{0, 1,  0, 1, 1, 1, 1, 0, 0, 0, 1, 0}; // k=8, line_start
      vecs[6]  = '{0, 1,  1, 1, 2, 1, 1, 0, 1, 0, 0, 0}; // k=9
      vecs[7]  = '{0, 16, 1, 3, 2, 3, 1, 0, 0, 1, 0, 0}; // k=25, vblank
      vecs[8]  = '{0, 8,  1, 4, 2, 4, 1, 1, 0, 1, 0, 0}; // k=33, vsync
      vecs[9]  = '{0, 8,  1, 5, 2, 5, 1, 0, 0, 1, 0, 0}; // k=41
      vecs[10] = '{0, 6,  7, 5, 0, 0, 0, 0, 0, 1, 0, 0}; // k=47, (7,5)->(0,0)
      vecs[11] = '{0, 1,  0, 0, 1, 0, 1, 0, 0, 1, 1, 1}; // k=48, frame_start
      vecs[12] = '{0, 1,  1, 0, 2, 0, 1, 0, 1, 0, 0, 0}; // k=49
      vecs[13] = '{1, 1,  0, 0, 1, 0, 1, 0, 0, 0, 0, 0}; // mid-line reset

      #1;
      for (int i = 0; i < 14; i++) begin
         rst_small = vecs[i].rst;
         tick(vecs[i].n_clk);
         check($sformatf("v%0d x", i),      int'(small_if.x),           vecs[i].x);
         check($sformatf("v%0d y", i),      int'(small_if.y),           vecs[i].y);
         check($sformatf("v%0d x_next", i), int'(small_if.x_next),      vecs[i].xn);
         check($sformatf("v%0d y_next", i), int'(small_if.y_next),      vecs[i].yn);
         check($sformatf("v%0d hsync", i),  int'(small_if.hsync),       int'(vecs[i].hs));
         check($sformatf("v%0d vsync", i),  int'(small_if.vsync),       int'(vecs[i].vs));
         check($sformatf("v%0d en", i),     int'(small_if.en),          int'(vecs[i].en));
         check($sformatf("v%0d vblank", i), int'(small_if.vblank),      int'(vecs[i].vb));
         check($sformatf("v%0d line_st", i), int'(small_if.line_start), int'(vecs[i].ls));
         check($sformatf("v%0d frame_st", i), int'(small_if.frame_start), int'(vecs[i].fs));
         check($sformatf("v%0d pix_tick", i), int'(small_if.pix_tick),
               vecs[i].rst ? 1 : 1);
      end

      // Full x/y scan of one small frame after a fresh release
      rst_small = 1'b1;
      tick(2);
      rst_small = 1'b0;
      for (int k = 1; k <= 48; k++) begin
         tick(1);
         check($sformatf("scan x k=%0d", k), int'(small_if.x), k % 8);
         check($sformatf("scan y k=%0d", k), int'(small_if.y), (k / 8) % 6);
      end

`ifdef VGA_TIMING_FRAME_CNT_EN
      // frame_cnt steps 0,1,2,3,0 on successive frame_start pulses
      rst_small = 1'b1;
      tick(2);
      check("frame_cnt reset", int'(small_if.frame_cnt), 0);
      rst_small = 1'b0;
      for (int f = 1; f <= 4; f++) begin
         cnt = 0;
         tick(1);
         while (!small_if.frame_start && cnt < 60) begin
            tick(1);
            cnt++;
         end
         check($sformatf("frame_start %0d seen", f), int'(small_if.frame_start), 1);
         check($sformatf("frame_cnt step %0d", f), int'(small_if.frame_cnt), f % 4);
      end
`endif

      // ---------------- default raster ----------------
      rst_big = 1'b1;
      tick(3);
      check("big rst hsync", int'(big_if.hsync), 0);
      check("big rst vsync", int'(big_if.vsync), 0);
      check("big rst en",    int'(big_if.en),    0);
      check("big rst x",     int'(big_if.x),     0);
      check("big rst y",     int'(big_if.y),     0);
      check("big rst ls",    int'(big_if.line_start), 0);
      rst_big = 1'b0;
      tick(1);
      t = 1;
      check("big en after release", int'(big_if.en), 1);
      check("big x still 0 at clk 1", int'(big_if.x), 0);

      while (big_if.x != 10'd656 && t < 2000) begin
         tick(1);
         t++;
      end
      check("big x=656 clk", t, 1312);
      tick(1);
      t++;
      check("big hsync rise at 1313", int'(big_if.hsync), 1);
      cnt = 0;
      while (big_if.hsync && cnt < 400) begin
         cnt++;
         tick(1);
         t++;
      end
      check("big hsync width", cnt, 192);

      while (!big_if.line_start && t < 2000) begin
         tick(1);
         t++;
      end
      check("big first line_start clk", t, 1600);
      tick(1);
      t++;
      while (!big_if.line_start && t < 4000) begin
         tick(1);
         t++;
      end
      check("big second line_start clk", t, 3200);

      // Mid-frame reset at (300,2)
      while (!(big_if.x == 10'd300 && big_if.y == 10'd2) && t < 6000) begin
         tick(1);
         t++;
      end
      check("big reach (300,2) clk", t, 3800);
      rst_big = 1'b1;
      tick(1);
      check("mid rst x",     int'(big_if.x),          0);
      check("mid rst y",     int'(big_if.y),          0);
      check("mid rst hsync", int'(big_if.hsync),      0);
      check("mid rst vsync", int'(big_if.vsync),      0);
      check("mid rst ls",    int'(big_if.line_start), 0);
      check("mid rst en",    int'(big_if.en),         0);
      rst_big = 1'b0;
      early = 0;
      for (int k = 1; k <= 1600; k++) begin
         tick(1);
         if (k == 1312) check("mid x=656 at 1312", int'(big_if.x), 656);
         if (k == 1313) check("mid hsync at 1313", int'(big_if.hsync), 1);
         if (k < 1600) early += int'(big_if.line_start);
         else check("mid line_start at 1600", int'(big_if.line_start), 1);
      end
      check("mid no early line_start", early, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
